// File: rtl/multicycle_control_pkg.sv
// mips_ctrl_pkg: state, opcode and control-field encodings for the multicycle MIPS control FSM.
// Rev 1.0 - initial release.
`default_nettype none

package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // States whose return to FETCH completes an instruction.
  function automatic logic is_retire_state(input state_t s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALUWB) ||
           (s == S_BRANCH) || (s == S_ADDIWB) || (s == S_JUMP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/flag inputs and datapath control outputs of the control FSM.
// Rev 1.0 - initial release.
`default_nettype none

interface multicycle_control_if #(
  parameter int COUNT_W = 32
);
  logic [5:0]         opcode;
  logic               zero;
  logic               mem_ready;
  logic               pc_en;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_source;
  logic [3:0]         state;
  logic               illegal;
  logic [COUNT_W-1:0] retired;

  modport slave (
    input  opcode, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state, illegal, retired
  );

  modport master (
    output opcode, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state, illegal, retired
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_ctrl_output_decode.sv
// ctrl_output_decode: combinational Moore decode of FSM state (plus zero/mem_ready) to datapath controls.
// Rev 1.0 - initial release.
`default_nettype none

module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_zero,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        // IR load and PC bump fire only on the cycle the fetch completes.
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_en     = i_mem_ready;
        o_ctrl.alu_src_b = SRCB_FOUR;
      end
      S_DECODE: o_ctrl.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR, S_ADDIEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.iord     = 1'b1;
        o_ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.iord      = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALU_SUB;
        o_ctrl.pc_source = PCSRC_ALUOUT;
        o_ctrl.pc_en     = i_zero;
      end
      S_ADDIWB: o_ctrl.reg_write = 1'b1;
      S_JUMP: begin
        o_ctrl.pc_source = PCSRC_JUMP;
        o_ctrl.pc_en     = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle MIPS core, with illegal-opcode pulse and retired counter.
// Optional MEM_WAIT_EN: FETCH/MEMRD/MEMWR stall on mem_ready. Rev 1.0 - initial release.
`default_nettype none

module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.slave  bus
);

  state_t             r_state;
  state_t             w_next;
  logic [5:0]         r_opcode;
  logic               r_illegal;
  logic [COUNT_W-1:0] r_retired;
  logic               w_mem_go;
  logic               w_illegal_op;
  ctrl_t              w_ctrl;

`ifdef MEM_WAIT_EN
  assign w_mem_go = bus.mem_ready;
`else
  // Memory always completes in one cycle; mem_ready has no effect.
  assign w_mem_go = bus.mem_ready | 1'b1;
`endif

  always_comb begin
    w_next       = S_FETCH;
    w_illegal_op = 1'b0;
    case (r_state)
      S_IDLE:    w_next = S_FETCH;
      S_FETCH:   w_next = w_mem_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next       = S_FETCH;
            w_illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR:  w_next = (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = w_mem_go ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_next = w_mem_go ? S_FETCH : S_MEMWR;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_opcode  <= '0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state   <= w_next;
      r_illegal <= w_illegal_op;
      if (r_state == S_DECODE) begin
        r_opcode <= bus.opcode;
      end
      if (is_retire_state(r_state) && (w_next == S_FETCH)) begin
        r_retired <= r_retired + COUNT_W'(1);
      end
    end
  end

  ctrl_output_decode u_decode (
    .i_state     (r_state),
    .i_zero      (bus.zero),
    .i_mem_ready (w_mem_go),
    .o_ctrl      (w_ctrl)
  );

  assign bus.pc_en      = w_ctrl.pc_en;
  assign bus.iord       = w_ctrl.iord;
  assign bus.mem_read   = w_ctrl.mem_read;
  assign bus.mem_write  = w_ctrl.mem_write;
  assign bus.ir_write   = w_ctrl.ir_write;
  assign bus.reg_dst    = w_ctrl.reg_dst;
  assign bus.mem_to_reg = w_ctrl.mem_to_reg;
  assign bus.reg_write  = w_ctrl.reg_write;
  assign bus.alu_src_a  = w_ctrl.alu_src_a;
  assign bus.alu_src_b  = w_ctrl.alu_src_b;
  assign bus.alu_op     = w_ctrl.alu_op;
  assign bus.pc_source  = w_ctrl.pc_source;
  assign bus.state      = r_state;
  assign bus.illegal    = r_illegal;
  assign bus.retired    = r_retired;

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

- Moore-style main control FSM for the team's multicycle MIPS core.
- Consumes the 6-bit opcode from the instruction decoder and the ALU `zero` flag.
- Sequences fetch, decode, execute, memory and writeback by driving the datapath enables and mux selects.
- Also reports illegal opcodes and keeps a retired-instruction counter.

## Interface
Parameters:
- `COUNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  instruction[31:26], from the decoder; sampled in DECODE only.
- `zero`  in  1  ALU zero flag; used in BRANCH only.
- `mem_ready`  in  1  memory handshake. Used only when `MEM_WAIT_EN` is defined.
- `pc_en`  out  1  PC write enable (unconditional write, or branch taken).
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  instruction register load.
- `reg_dst`  out  1  write-register select: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  writeback data select: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = A.
- `alu_src_b`  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_op`  out  2  ALU operation: 00 = add, 01 = subtract, 10 = use funct.
- `pc_source`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state`  out  4  current state, for debug.
- `illegal`  out  1  registered one-cycle pulse on an unsupported opcode.
- `retired`  out  `COUNT_W`  count of completed instructions.

## Operation
States and encodings:
- IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXECUTE 7, ALUWB 8, BRANCH 9, ADDIEX 10, ADDIWB 11, JUMP 12.
- Encodings 13–15 are unreachable; if entered, go to FETCH.

Reset:
- `reset` forces state to IDLE, `retired` to 0 and `illegal` to 0.
- In IDLE every control output is 0.
- IDLE always moves to FETCH on the next edge.

Control outputs per state. Any signal not listed is 0.
- FETCH: `mem_read`=1, `ir_write`=1, `pc_en`=1, `alu_src_b`=01. Next: DECODE.
- DECODE: `alu_src_b`=11. Next state depends on opcode:
  - 100011 (LW) or 101011 (SW) → MEMADR
  - 000000 (R-type) → EXECUTE
  - 000100 (BEQ) → BRANCH
  - 001000 (ADDI) → ADDIEX
  - 000010 (J) → JUMP
  - any other opcode → FETCH, with `illegal` pulsed high for one cycle on that edge
- MEMADR: `alu_src_a`=1, `alu_src_b`=10. Next: MEMRD for LW, MEMWR for SW, using the opcode latched in DECODE.
- MEMRD: `iord`=1, `mem_read`=1. Next: MEMWB.
- MEMWB: `mem_to_reg`=1, `reg_write`=1. Next: FETCH.
- MEMWR: `iord`=1, `mem_write`=1. Next: FETCH.
- EXECUTE: `alu_src_a`=1, `alu_op`=10. Next: ALUWB.
- ALUWB: `reg_dst`=1, `reg_write`=1. Next: FETCH.
- BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_source`=01, `pc_en`=`zero`. Next: FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10. Next: ADDIWB.
- ADDIWB: `reg_write`=1. Next: FETCH.
- JUMP: `pc_source`=10, `pc_en`=1. Next: FETCH.

Other rules:
- The opcode is latched into an internal register in DECODE. Later opcode changes have no effect.
- `retired` increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP.
  - Illegal-opcode returns do not count.
  - The counter wraps modulo 2^`COUNT_W`.

## Timing
- Control outputs are a combinational decode of the registered state (and of `zero` / `mem_ready` where stated).
- Cycles per instruction, no wait states, FETCH to next FETCH: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal 2.
- `illegal` is high during the first FETCH cycle after the illegal DECODE.
- `retired` updates on the same edge that enters FETCH.
- Reset may assert in any state, including mid-wait. State goes to IDLE immediately (asynchronous) and in-progress strobes drop at once.

## Configuration
`MEM_WAIT_EN` defined:
- FETCH, MEMRD and MEMWR hold while `mem_ready`=0, keeping `mem_read`/`mem_write` and `iord` asserted.
- In FETCH, `ir_write` and `pc_en` are gated with `mem_ready`, so each fires exactly once.
- The state advances on the edge where `mem_ready`=1.
- A MEMWR completion is counted in `retired` only on that advancing edge.

`MEM_WAIT_EN` undefined:
- `mem_ready` is ignored.
- Every memory state takes exactly one cycle.

## Structure
- Package `mips_ctrl_pkg` holds:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - `alu_op`, `alu_src_b` and `pc_source` encodings
- One combinational sub-module, `ctrl_output_decode`, maps state, `zero` and `mem_ready` to the control outputs.
- The top level holds the state register, opcode latch, `illegal` register and `retired` counter.

## Test plan
- Reset asserted, then released → `state`=0 for one cycle with all controls 0; next cycle `state`=1 with `mem_read`=1, `ir_write`=1, `pc_en`=1.
- Opcode 100011 → state sequence 1,2,3,4,5,1; `reg_write`=1 and `mem_to_reg`=1 in state 5; `retired` goes 0→1.
- Opcode 000100 with `zero`=1, then again with `zero`=0 → `pc_en`=1 in BRANCH for the first, 0 for the second; both increment `retired`.
- Opcode 111111 → DECODE→FETCH, `illegal`=1 for exactly one cycle, `retired` unchanged.
- With `MEM_WAIT_EN` defined, LW with `mem_ready` low for 3 cycles in both FETCH and MEMRD → instruction takes 11 cycles; `ir_write` high in exactly 1 cycle.
- `COUNT_W`=4, 16 J instructions → `retired` wraps to 0; reset asserted mid-MEMWR → `mem_write` drops in the same cycle and `state`=0.
